// File: rtl/cc_itf_pkg.sv
// Core-complex interface package: crossbar slave-port AXI4 typedefs plus the
// external-access master state enum. SOPHON_EXT_ACCESS_TIMEOUT_EN adds the drain state.
package CC_ITF_PKG;

  localparam int unsigned XBAR_ADDR_WIDTH = 32;
  localparam int unsigned XBAR_DATA_WIDTH = 64;
  localparam int unsigned XBAR_ID_WIDTH   = 4;
  localparam int unsigned XBAR_USER_WIDTH = 1;

  localparam logic [2:0] AXI_SIZE_D64   = 3'd3;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  localparam int unsigned EXT_ACCESS_TIMEOUT_CYCLES = 1024;

  typedef struct packed {
    logic [XBAR_ID_WIDTH-1:0]   id;
    logic [XBAR_ADDR_WIDTH-1:0] addr;
    logic [7:0]                 len;
    logic [2:0]                 size;
    logic [1:0]                 burst;
    logic                       lock;
    logic [3:0]                 cache;
    logic [2:0]                 prot;
    logic [3:0]                 qos;
    logic [3:0]                 region;
    logic [5:0]                 atop;
    logic [XBAR_USER_WIDTH-1:0] user;
  } xbar_slv_port_d64_aw_chan_t;

  typedef struct packed {
    logic [XBAR_ID_WIDTH-1:0]   id;
    logic [XBAR_ADDR_WIDTH-1:0] addr;
    logic [7:0]                 len;
    logic [2:0]                 size;
    logic [1:0]                 burst;
    logic                       lock;
    logic [3:0]                 cache;
    logic [2:0]                 prot;
    logic [3:0]                 qos;
    logic [3:0]                 region;
    logic [XBAR_USER_WIDTH-1:0] user;
  } xbar_slv_port_d64_ar_chan_t;

  typedef struct packed {
    logic [XBAR_DATA_WIDTH-1:0]   data;
    logic [XBAR_DATA_WIDTH/8-1:0] strb;
    logic                         last;
    logic [XBAR_USER_WIDTH-1:0]   user;
  } xbar_slv_port_d64_w_chan_t;

  typedef struct packed {
    logic [XBAR_ID_WIDTH-1:0]   id;
    logic [1:0]                 resp;
    logic [XBAR_USER_WIDTH-1:0] user;
  } xbar_slv_port_d64_b_chan_t;

  typedef struct packed {
    logic [XBAR_ID_WIDTH-1:0]   id;
    logic [XBAR_DATA_WIDTH-1:0] data;
    logic [1:0]                 resp;
    logic                       last;
    logic [XBAR_USER_WIDTH-1:0] user;
  } xbar_slv_port_d64_r_chan_t;

  typedef struct packed {
    xbar_slv_port_d64_aw_chan_t aw;
    logic                       aw_valid;
    xbar_slv_port_d64_w_chan_t  w;
    logic                       w_valid;
    logic                       b_ready;
    xbar_slv_port_d64_ar_chan_t ar;
    logic                       ar_valid;
    logic                       r_ready;
  } xbar_slv_port_d64_req_t;

  typedef struct packed {
    logic                       aw_ready;
    logic                       ar_ready;
    logic                       w_ready;
    logic                       b_valid;
    xbar_slv_port_d64_b_chan_t  b;
    logic                       r_valid;
    xbar_slv_port_d64_r_chan_t  r;
  } xbar_slv_port_d64_resps_t;

  typedef enum logic [2:0] {
    StIdle,
    StWr,
    StWrB,
    StRdAr,
    StRdR,
    StRsp
`ifdef SOPHON_EXT_ACCESS_TIMEOUT_EN
    , StDrain
`endif
  } ext_access_state_e;

endpackage

// File: rtl/axi_ext_access_master.sv
// Single-beat AXI4 initiator for the core complex external-access slave port.
// Define SOPHON_EXT_ACCESS_TIMEOUT_EN to time out B/R waits and drain late beats.
module axi_ext_access_master
  import CC_ITF_PKG::*;
#(
  parameter int unsigned ADDR_WIDTH     = XBAR_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH     = XBAR_DATA_WIDTH,
  parameter int unsigned AXI_ID         = 0,
  parameter int unsigned TIMEOUT_CYCLES = EXT_ACCESS_TIMEOUT_CYCLES
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      cmd_valid_i,
  output logic                      cmd_ready_o,
  input  logic                      cmd_we_i,
  input  logic [ADDR_WIDTH-1:0]     cmd_addr_i,
  input  logic [DATA_WIDTH-1:0]     cmd_wdata_i,
  input  logic [DATA_WIDTH/8-1:0]   cmd_strb_i,
  output logic                      rsp_valid_o,
  input  logic                      rsp_ready_i,
  output logic [DATA_WIDTH-1:0]     rsp_rdata_o,
  output logic                      rsp_err_o,
  output xbar_slv_port_d64_req_t    axi_req_o,
  input  xbar_slv_port_d64_resps_t  axi_rsp_i
);

  ext_access_state_e state_q, state_d;
  logic aw_pend_q, aw_pend_d, w_pend_q, w_pend_d;
  logic we_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH/8-1:0] strb_q;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic err_q, err_d;
  logic accept;

  assign accept = (state_q == StIdle) && cmd_valid_i;

`ifdef SOPHON_EXT_ACCESS_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CntW-1:0] cnt_q, cnt_d;
  logic timed_out_q, timed_out_d;
  logic expire;

  assign expire = (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q       <= '0;
      timed_out_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      timed_out_q <= timed_out_d;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{32'(TIMEOUT_CYCLES)};
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      aw_pend_q <= 1'b0;
      w_pend_q  <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      strb_q    <= '0;
    end else begin
      state_q   <= state_d;
      aw_pend_q <= aw_pend_d;
      w_pend_q  <= w_pend_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      if (accept) begin
        we_q    <= cmd_we_i;
        addr_q  <= cmd_addr_i;
        wdata_q <= cmd_wdata_i;
        strb_q  <= cmd_strb_i;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    aw_pend_d   = aw_pend_q;
    w_pend_d    = w_pend_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    cmd_ready_o = 1'b0;
    rsp_valid_o = 1'b0;
`ifdef SOPHON_EXT_ACCESS_TIMEOUT_EN
    cnt_d       = cnt_q;
    timed_out_d = timed_out_q;
`endif
    unique case (state_q)
      StIdle: begin
        cmd_ready_o = 1'b1;
        if (cmd_valid_i) begin
          rdata_d = '0;
          err_d   = 1'b0;
          if (cmd_we_i) begin
            aw_pend_d = 1'b1;
            w_pend_d  = 1'b1;
            state_d   = StWr;
          end else begin
            state_d = StRdAr;
          end
        end
      end
      StWr: begin
        // AW and W retire independently; B wait starts once both have gone.
        if (aw_pend_q && axi_rsp_i.aw_ready) aw_pend_d = 1'b0;
        if (w_pend_q && axi_rsp_i.w_ready) w_pend_d = 1'b0;
        if (!aw_pend_d && !w_pend_d) begin
          state_d = StWrB;
`ifdef SOPHON_EXT_ACCESS_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      StWrB: begin
        if (axi_rsp_i.b_valid) begin
          err_d   = axi_rsp_i.b.resp[1];
          state_d = StRsp;
`ifdef SOPHON_EXT_ACCESS_TIMEOUT_EN
        end else if (expire) begin
          err_d       = 1'b1;
          timed_out_d = 1'b1;
          state_d     = StRsp;
        end else begin
          cnt_d = cnt_q + CntW'(1);
`endif
        end
      end
      StRdAr: begin
        if (axi_rsp_i.ar_ready) begin
          state_d = StRdR;
`ifdef SOPHON_EXT_ACCESS_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      StRdR: begin
        if (axi_rsp_i.r_valid) begin
          rdata_d = axi_rsp_i.r.data;
          err_d   = axi_rsp_i.r.resp[1];
          state_d = StRsp;
`ifdef SOPHON_EXT_ACCESS_TIMEOUT_EN
        end else if (expire) begin
          rdata_d     = '0;
          err_d       = 1'b1;
          timed_out_d = 1'b1;
          state_d     = StRsp;
        end else begin
          cnt_d = cnt_q + CntW'(1);
`endif
        end
      end
      StRsp: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) begin
          state_d = StIdle;
`ifdef SOPHON_EXT_ACCESS_TIMEOUT_EN
          if (timed_out_q) state_d = StDrain;
`endif
        end
      end
`ifdef SOPHON_EXT_ACCESS_TIMEOUT_EN
      StDrain: begin
        if (we_q ? axi_rsp_i.b_valid : axi_rsp_i.r_valid) begin
          timed_out_d = 1'b0;
          state_d     = StIdle;
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    axi_req_o          = '0;
    axi_req_o.aw.id    = XBAR_ID_WIDTH'(AXI_ID);
    axi_req_o.aw.addr  = addr_q;
    axi_req_o.aw.size  = AXI_SIZE_D64;
    axi_req_o.aw.burst = AXI_BURST_INCR;
    axi_req_o.aw_valid = aw_pend_q;
    axi_req_o.w.data   = wdata_q;
    axi_req_o.w.strb   = strb_q;
    axi_req_o.w.last   = 1'b1;
    axi_req_o.w_valid  = w_pend_q;
    axi_req_o.ar.id    = XBAR_ID_WIDTH'(AXI_ID);
    axi_req_o.ar.addr  = addr_q;
    axi_req_o.ar.size  = AXI_SIZE_D64;
    axi_req_o.ar.burst = AXI_BURST_INCR;
    axi_req_o.ar_valid = (state_q == StRdAr);
    axi_req_o.b_ready  = (state_q == StWrB);
    axi_req_o.r_ready  = (state_q == StRdR);
`ifdef SOPHON_EXT_ACCESS_TIMEOUT_EN
    if (state_q == StDrain) begin
      axi_req_o.b_ready = we_q;
      axi_req_o.r_ready = !we_q;
    end
`endif
  end

  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;

  logic unused_rsp;
  assign unused_rsp = ^{axi_rsp_i.b.id, axi_rsp_i.b.user, axi_rsp_i.b.resp[0],
                        axi_rsp_i.r.id, axi_rsp_i.r.user, axi_rsp_i.r.resp[0],
                        axi_rsp_i.r.last};

endmodule
